// File: rtl/data_ram.sv
// Byte-addressed 32-bit data RAM with sub-word loads/stores, alignment/range
// checking and a 1- or 2-cycle fully pipelined response path.
module data_ram #(
    parameter int WORDS    = 64,
    parameter int READ_LAT = 1
) (
    input  logic        CLK,
    input  logic        RST_N,
    input  logic        REQ,
    input  logic        WE,
    input  logic [1:0]  SIZE,
    input  logic        UNS,
    input  logic [31:0] A,
    input  logic [31:0] WD,
    output logic [31:0] RD,
    output logic        ACK,
    output logic        ERR
);

    localparam int AW = (WORDS > 1) ? $clog2(WORDS) : 1;
    localparam logic [29:0] WORDS_W = 30'(WORDS);

    logic [31:0] mem [WORDS];

    logic          accept;
    logic [29:0]   word_idx;
    logic [AW-1:0] idx;
    logic          bad;
    logic [3:0]    be;
    logic [31:0]   wdata;

    // Requests presented while reset is held are never accepted.
    assign accept   = REQ & RST_N;
    assign word_idx = A[31:2];
    assign idx      = A[AW+1:2];

    always_comb begin
        bad = 1'b0;
        case (SIZE)
            2'b01:   bad = A[0];
            2'b10:   bad = |A[1:0];
            2'b11:   bad = 1'b1;
            default: bad = 1'b0;
        endcase
        if (word_idx >= WORDS_W) bad = 1'b1;
    end

    always_comb begin
        be    = 4'b0000;
        wdata = WD;
        case (SIZE)
            2'b00: begin
                be    = 4'b0001 << A[1:0];
                wdata = {4{WD[7:0]}};
            end
            2'b01: begin
                be    = A[1] ? 4'b1100 : 4'b0011;
                wdata = {2{WD[15:0]}};
            end
            2'b10:   be = 4'b1111;
            default: be = 4'b0000;
        endcase
    end

    // Storage and read port carry no reset so contents survive RST_N pulses.
    logic [31:0] rword;

    always_ff @(posedge CLK) begin
        if (accept && !bad) begin
            if (WE) begin
                for (int i = 0; i < 4; i++) begin
                    if (be[i]) mem[idx][8*i +: 8] <= wdata[8*i +: 8];
                end
            end else begin
                rword <= mem[idx];
            end
        end
    end

    logic       s1_valid;
    logic       s1_err;
    logic       s1_we;
    logic [1:0] s1_size;
    logic       s1_uns;
    logic [1:0] s1_lane;

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            s1_valid <= 1'b0;
            s1_err   <= 1'b0;
            s1_we    <= 1'b0;
            s1_size  <= 2'b00;
            s1_uns   <= 1'b0;
            s1_lane  <= 2'b00;
        end else begin
            s1_valid <= accept;
            s1_err   <= bad;
            s1_we    <= WE;
            s1_size  <= SIZE;
            s1_uns   <= UNS;
            s1_lane  <= A[1:0];
        end
    end

    logic [31:0] shifted;
    logic [31:0] fmt;
    logic [31:0] resp_rd;
    logic        resp_ack;
    logic        resp_err;

    assign shifted = rword >> {s1_lane, 3'b000};

    always_comb begin
        fmt = 32'd0;
        case (s1_size)
            2'b00:   fmt = {{24{~s1_uns & shifted[7]}}, shifted[7:0]};
            2'b01:   fmt = {{16{~s1_uns & shifted[15]}}, shifted[15:0]};
            2'b10:   fmt = rword;
            default: fmt = 32'd0;
        endcase
    end

    // Everything is gated by the valid bit so RD/ERR stay 0 between ACKs.
    assign resp_ack = s1_valid;
    assign resp_err = s1_valid & s1_err;
    assign resp_rd  = (s1_valid && !s1_err && !s1_we) ? fmt : 32'd0;

    generate
        if (READ_LAT == 2) begin : g_lat2
            logic        ack_q;
            logic        err_q;
            logic [31:0] rd_q;

            always_ff @(posedge CLK or negedge RST_N) begin
                if (!RST_N) begin
                    ack_q <= 1'b0;
                    err_q <= 1'b0;
                    rd_q  <= 32'd0;
                end else begin
                    ack_q <= resp_ack;
                    err_q <= resp_err;
                    rd_q  <= resp_rd;
                end
            end

            assign ACK = ack_q;
            assign ERR = err_q;
            assign RD  = rd_q;
        end else begin : g_lat1
            assign ACK = resp_ack;
            assign ERR = resp_err;
            assign RD  = resp_rd;
        end
    endgenerate

endmodule

// File: tb/tb_data_ram.sv
// Directed bench for data_ram: one READ_LAT=1 and one READ_LAT=2 instance
// share stimulus; each has its own expected-response queue.
module tb_data_ram;

    localparam int WORDS = 64;

    logic        CLK;
    logic        RST_N;
    logic        REQ;
    logic        WE;
    logic [1:0]  SIZE;
    logic        UNS;
    logic [31:0] A;
    logic [31:0] WD;
    logic [31:0] rd1, rd2;
    logic        ack1, ack2, err1, err2;

    data_ram #(.WORDS(WORDS), .READ_LAT(1)) u_lat1 (
        .CLK(CLK), .RST_N(RST_N), .REQ(REQ), .WE(WE), .SIZE(SIZE), .UNS(UNS),
        .A(A), .WD(WD), .RD(rd1), .ACK(ack1), .ERR(err1)
    );

    data_ram #(.WORDS(WORDS), .READ_LAT(2)) u_lat2 (
        .CLK(CLK), .RST_N(RST_N), .REQ(REQ), .WE(WE), .SIZE(SIZE), .UNS(UNS),
        .A(A), .WD(WD), .RD(rd2), .ACK(ack2), .ERR(err2)
    );

    // ---------------- clock / reset ----------------
    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    int edge_n = 0;
    always @(posedge CLK) edge_n++;

    // ---------------- scoreboard ----------------
    typedef struct {
        logic [31:0] rd;
        logic        err;
        int          due;
    } exp_t;

    exp_t exp_q1[$];
    exp_t exp_q2[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s @edge %0d: got %h expected %h", name, edge_n, act, exp);
        end
    endtask

    task automatic expect_resp(input logic [31:0] rd, input logic err);
        exp_t e;
        e.rd  = rd;
        e.err = err;
        e.due = edge_n + 1;
        exp_q1.push_back(e);
        e.due = edge_n + 2;
        exp_q2.push_back(e);
    endtask

    task automatic mon(input int d, input logic ack, input logic err, input logic [31:0] rd);
        exp_t e;
        int   qs;
        string tag;
        tag = (d == 0) ? "lat1" : "lat2";
        qs  = (d == 0) ? exp_q1.size() : exp_q2.size();
        if (ack) begin
            if (qs == 0) begin
                chk({tag, " unexpected_ack"}, 32'd1, 32'd0);
            end else begin
                e = (d == 0) ? exp_q1.pop_front() : exp_q2.pop_front();
                chk({tag, " ack_edge"}, 32'(edge_n), 32'(e.due));
                chk({tag, " rd"}, rd, e.rd);
                chk({tag, " err"}, {31'd0, err}, {31'd0, e.err});
            end
        end else begin
            chk({tag, " idle_rd_err"}, {rd[31:1], rd[0] | err}, 32'd0);
            if (qs != 0) begin
                e = (d == 0) ? exp_q1[0] : exp_q2[0];
                if (e.due <= edge_n) begin
                    chk({tag, " missing_ack"}, 32'd0, 32'd1);
                    if (d == 0) void'(exp_q1.pop_front());
                    else        void'(exp_q2.pop_front());
                end
            end
        end
    endtask

    always @(negedge CLK) begin
        mon(0, ack1, err1, rd1);
        mon(1, ack2, err2, rd2);
    end

    // ---------------- driver ----------------
    task automatic drive(input logic we, input logic [1:0] size, input logic uns,
                         input logic [31:0] a, input logic [31:0] wd);
        REQ  = 1'b1;
        WE   = we;
        SIZE = size;
        UNS  = uns;
        A    = a;
        WD   = wd;
    endtask

    task automatic issue(input logic we, input logic [1:0] size, input logic uns,
                         input logic [31:0] a, input logic [31:0] wd,
                         input logic [31:0] exp_rd, input logic exp_err);
        @(posedge CLK);
        #1;
        drive(we, size, uns, a, wd);
        expect_resp(exp_rd, exp_err);
    endtask

    task automatic idle_drain();
        @(posedge CLK);
        #1;
        REQ = 1'b0;
        for (int i = 0; i < 20 && (exp_q1.size() != 0 || exp_q2.size() != 0); i++)
            @(posedge CLK);
        @(posedge CLK);
        #1;
        chk("drain_lat1", 32'(exp_q1.size()), 32'd0);
        chk("drain_lat2", 32'(exp_q2.size()), 32'd0);
    endtask

    // ---------------- vectors ----------------
    typedef struct {
        logic        we;
        logic [1:0]  size;
        logic        uns;
        logic [31:0] a;
        logic [31:0] wd;
        logic [31:0] rd;
        logic        err;
    } vec_t;

    vec_t        tbl[$];
    logic [31:0] sweep_val[WORDS];

    initial begin
        // SW/SB/loads on word 0x10, error cases, then store + 8 back-to-back loads.
        tbl.push_back('{1'b1, 2'b10, 1'b0, 32'h10,  32'hDEADBEEF, 32'h0,        1'b0});
        tbl.push_back('{1'b1, 2'b00, 1'b0, 32'h11,  32'hAAAAAA80, 32'h0,        1'b0});
        tbl.push_back('{1'b0, 2'b00, 1'b0, 32'h11,  32'h0,        32'hFFFFFF80, 1'b0});
        tbl.push_back('{1'b0, 2'b00, 1'b1, 32'h11,  32'h0,        32'h00000080, 1'b0});
        tbl.push_back('{1'b0, 2'b10, 1'b0, 32'h10,  32'h0,        32'hDEAD80EF, 1'b0});
        tbl.push_back('{1'b0, 2'b01, 1'b0, 32'h12,  32'h0,        32'hFFFFDEAD, 1'b0});
        tbl.push_back('{1'b0, 2'b01, 1'b1, 32'h12,  32'h0,        32'h0000DEAD, 1'b0});
        tbl.push_back('{1'b0, 2'b00, 1'b0, 32'h10,  32'h0,        32'hFFFFFFEF, 1'b0});
        tbl.push_back('{1'b0, 2'b01, 1'b0, 32'h10,  32'h0,        32'hFFFF80EF, 1'b0});
        tbl.push_back('{1'b1, 2'b01, 1'b0, 32'h13,  32'h0000FFFF, 32'h0,        1'b1});
        tbl.push_back('{1'b0, 2'b11, 1'b0, 32'h10,  32'h0,        32'h0,        1'b1});
        tbl.push_back('{1'b1, 2'b10, 1'b0, 32'h12,  32'h55555555, 32'h0,        1'b1});
        tbl.push_back('{1'b0, 2'b01, 1'b0, 32'h11,  32'h0,        32'h0,        1'b1});
        tbl.push_back('{1'b0, 2'b10, 1'b0, 32'h10,  32'h0,        32'hDEAD80EF, 1'b0});
        tbl.push_back('{1'b0, 2'b10, 1'b0, 32'h100, 32'h0,        32'h0,        1'b1});
        tbl.push_back('{1'b1, 2'b00, 1'b0, 32'h100, 32'h000000AA, 32'h0,        1'b1});
        tbl.push_back('{1'b0, 2'b10, 1'b1, 32'h10,  32'h0,        32'hDEAD80EF, 1'b0});
        tbl.push_back('{1'b1, 2'b10, 1'b0, 32'h20,  32'h12345678, 32'h0,        1'b0});
        tbl.push_back('{1'b0, 2'b10, 1'b0, 32'h20,  32'h0,        32'h12345678, 1'b0});
        tbl.push_back('{1'b0, 2'b00, 1'b1, 32'h20,  32'h0,        32'h00000078, 1'b0});
        tbl.push_back('{1'b0, 2'b00, 1'b1, 32'h21,  32'h0,        32'h00000056, 1'b0});
        tbl.push_back('{1'b0, 2'b00, 1'b0, 32'h22,  32'h0,        32'h00000034, 1'b0});
        tbl.push_back('{1'b0, 2'b00, 1'b1, 32'h23,  32'h0,        32'h00000012, 1'b0});
        tbl.push_back('{1'b0, 2'b01, 1'b0, 32'h20,  32'h0,        32'h00005678, 1'b0});
        tbl.push_back('{1'b0, 2'b01, 1'b0, 32'h22,  32'h0,        32'h00001234, 1'b0});
        tbl.push_back('{1'b0, 2'b10, 1'b0, 32'h10,  32'h0,        32'hDEAD80EF, 1'b0});

        RST_N = 1'b0;
        drive(1'b0, 2'b10, 1'b0, 32'h0, 32'h0);
        REQ = 1'b0;

        // Outputs held at zero while reset is asserted.
        repeat (3) @(posedge CLK);
        #1;
        chk("reset_ack", {30'd0, ack1, ack2}, 32'd0);
        chk("reset_rd_err", rd1 | rd2 | {30'd0, err1, err2}, 32'd0);
        @(negedge CLK);
        RST_N = 1'b1;

        // Word sweep.
        for (int i = 0; i < WORDS; i++) begin
            sweep_val[i] = $urandom;
            issue(1'b1, 2'b10, 1'b0, 32'(4 * i), sweep_val[i], 32'h0, 1'b0);
        end
        for (int i = 0; i < WORDS; i++)
            issue(1'b0, 2'b10, 1'($urandom_range(0, 1)), 32'(4 * i), 32'h0, sweep_val[i], 1'b0);
        idle_drain();

        // Table: sub-word, errors, back-to-back.
        for (int i = 0; i < tbl.size(); i++)
            issue(tbl[i].we, tbl[i].size, tbl[i].uns, tbl[i].a, tbl[i].wd, tbl[i].rd, tbl[i].err);
        idle_drain();

        // Reset while a load is in flight; a store presented during reset is ignored.
        issue(1'b0, 2'b10, 1'b0, 32'h20, 32'h0, 32'h12345678, 1'b0);
        @(posedge CLK);
        #2;
        RST_N = 1'b0;
        drive(1'b1, 2'b10, 1'b0, 32'h20, 32'hBADBAD00);
        exp_q1.delete();
        exp_q2.delete();
        #1;
        chk("rst_mid_ack", {30'd0, ack1, ack2}, 32'd0);
        chk("rst_mid_rd_err", rd1 | rd2 | {30'd0, err1, err2}, 32'd0);
        repeat (3) @(posedge CLK);
        @(negedge CLK);
        RST_N = 1'b1;
        drive(1'b0, 2'b10, 1'b0, 32'h20, 32'h0);
        expect_resp(32'h12345678, 1'b0);
        issue(1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 32'hDEAD80EF, 1'b0);
        issue(1'b0, 2'b00, 1'b0, 32'h11, 32'h0, 32'hFFFFFF80, 1'b0);
        idle_drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule
